// File: rtl/cpu_definitions.sv
// Shared Y86-64 definitions: instruction codes, memory-stage FSM encoding and
// the access-class decode used by the memory stage.
package cpu_definitions;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BEAT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_READ  = 2'd1,
        CLS_WRITE = 2'd2
    } mem_class_e;

    function automatic mem_class_e icode_class(input logic [3:0] icode);
        case (icode)
            IRMMOVQ, IPUSHQ, ICALL: return CLS_WRITE;
            IMRMOVQ, IPOPQ, IRET:   return CLS_READ;
            default:                return CLS_NONE;
        endcase
    endfunction

    // Stack pops/returns address through valA; everything else through valE.
    function automatic logic base_is_vale(input logic [3:0] icode);
        return (icode == IRMMOVQ) || (icode == IPUSHQ) ||
               (icode == ICALL)   || (icode == IMRMOVQ);
    endfunction

endpackage

// File: rtl/mem_beat_pack.sv
// Beat counter plus the write-slice and read-assembly shift registers that
// split one DATA_W word into DATA_W/BUS_W little-endian bus beats.
module mem_beat_pack #(
    parameter int DATA_W = 64,
    parameter int BUS_W  = 16,
    parameter int KW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              beat_i,
    input  logic [BUS_W-1:0]  rdata_i,
    output logic [KW-1:0]     k_o,
    output logic              last_o,
    output logic [BUS_W-1:0]  wslice_o,
    output logic [DATA_W-1:0] rasm_o
);

    localparam int N = DATA_W / BUS_W;

    logic [KW-1:0]     k_q, k_d;
    logic [DATA_W-1:0] wsh_q, wsh_d;
    logic [DATA_W-1:0] rsh_q, rsh_d;
    logic [DATA_W-1:0] rasm;

    assign last_o   = (k_q == KW'(N - 1));
    assign k_o      = k_q;
    assign wslice_o = wsh_q[BUS_W-1:0];
    assign rasm_o   = rasm;

    // Each read beat enters at the top so beat 0 ends up in the low bits.
    assign rasm = (rsh_q >> BUS_W) | (DATA_W'(rdata_i) << (DATA_W - BUS_W));

    always_comb begin
        k_d   = k_q;
        wsh_d = wsh_q;
        rsh_d = rsh_q;
        if (load_i) begin
            k_d   = '0;
            wsh_d = wdata_i;
            rsh_d = '0;
        end else if (beat_i) begin
            k_d   = last_o ? '0 : k_q + KW'(1);
            wsh_d = wsh_q >> BUS_W;
            rsh_d = rasm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    always_ff @(posedge clk) begin
        wsh_q <= wsh_d;
        rsh_q <= rsh_d;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage controller: runs one DATA_W access as N bus beats.
// Optional misalignment fault is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl
    import cpu_definitions::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BUS_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BUS_W-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [BUS_W-1:0]  mem_rdata
);

    localparam int N  = DATA_W / BUS_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if ((BUS_W != 8 && BUS_W != 16 && BUS_W != 32 && BUS_W != 64) ||
        (DATA_W % BUS_W) != 0) begin : g_bad_bus
        $error("mem_access_ctrl: BUS_W must be 8/16/32/64 and divide DATA_W");
    end

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] valm_q, valm_d;
    logic              load;
    logic              beat_fire;

    mem_class_e        cls;
    logic [ADDR_W-1:0] start_base;
    logic [DATA_W-1:0] start_wdata;

    logic [KW-1:0]     k;
    logic              last;
    logic [BUS_W-1:0]  wslice;
    logic [DATA_W-1:0] rasm;

    assign cls         = icode_class(icode);
    assign start_base  = base_is_vale(icode) ? valE : valA[ADDR_W-1:0];
    assign start_wdata = (icode == ICALL) ? valP : valA;
    // mem_ack is only honoured while a beat is actually being requested.
    assign beat_fire   = (state_q == ST_BEAT) && mem_ack;

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q, err_d;
    logic misaligned;
    assign misaligned = (start_base & ADDR_W'(DATA_W / 8 - 1)) != '0;
    assign dmem_error = err_q;
`else
    assign dmem_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        valm_d  = valm_q;
        load    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d = start_base;
                    wr_d   = (cls == CLS_WRITE);
                    rd_d   = (cls == CLS_READ);
`ifdef MEM_ALIGN_CHECK_EN
                    err_d  = 1'b0;
`endif
                    if (cls == CLS_NONE) begin
                        state_d = ST_DONE;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (misaligned) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_BEAT;
                        load    = 1'b1;
                    end
                end
            end
            ST_BEAT: begin
                if (beat_fire && last) begin
                    state_d = ST_DONE;
                    if (rd_q) valm_d = rasm;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            valm_q  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            valm_q  <= valm_d;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

    mem_beat_pack #(
        .DATA_W (DATA_W),
        .BUS_W  (BUS_W),
        .KW     (KW)
    ) u_beat_pack (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .wdata_i  (start_wdata),
        .beat_i   (beat_fire),
        .rdata_i  (mem_rdata),
        .k_o      (k),
        .last_o   (last),
        .wslice_o (wslice),
        .rasm_o   (rasm)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign valM      = valm_q;
    assign mem_req   = (state_q == ST_BEAT);
    assign mem_we    = mem_req && wr_q;
    assign mem_addr  = mem_req ? base_q + ADDR_W'(k) * ADDR_W'(BUS_W / 8) : '0;
    assign mem_wdata = mem_req ? wslice : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with BUS_W=16, DATA_W=64 (four beats).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        busy, done, dmem_error;
    logic [63:0] valM;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64), .BUS_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .icode      (icode),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .busy       (busy),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; icode = 4'h0;
        valE = '0; valA = '0; valP = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        nvec++; if (busy !== 1'b0)      begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0)      begin nerr++; $display("FAIL rst_done got %b want 0", done); end
        nvec++; if (mem_req !== 1'b0)   begin nerr++; $display("FAIL rst_req got %b want 0", mem_req); end
        nvec++; if (mem_we !== 1'b0)    begin nerr++; $display("FAIL rst_we got %b want 0", mem_we); end
        nvec++; if (mem_addr !== 64'h0) begin nerr++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        nvec++; if (mem_wdata !== 16'h0) begin nerr++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
        nvec++; if (valM !== 64'h0)     begin nerr++; $display("FAIL rst_valM got %h want 0", valM); end
        nvec++; if (dmem_error !== 1'b0) begin nerr++; $display("FAIL rst_err got %b want 0", dmem_error); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_irmmovq();
        logic [63:0] ea [4] = '{64'h100, 64'h102, 64'h104, 64'h106};
        logic [15:0] ew [4] = '{16'h7788, 16'h5566, 16'h3344, 16'h1122};
        mem_ack = 1'b1;
        icode = 4'h4; valE = 64'h100; valA = 64'h1122334455667788; valP = 64'hDEAD;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nvec++; if (mem_req !== 1'b1)   begin nerr++; $display("FAIL rmw_req[%0d] got %b want 1", k, mem_req); end
            nvec++; if (mem_we !== 1'b1)    begin nerr++; $display("FAIL rmw_we[%0d] got %b want 1", k, mem_we); end
            nvec++; if (mem_addr !== ea[k]) begin nerr++; $display("FAIL rmw_addr[%0d] got %h want %h", k, mem_addr, ea[k]); end
            nvec++; if (mem_wdata !== ew[k]) begin nerr++; $display("FAIL rmw_wdata[%0d] got %h want %h", k, mem_wdata, ew[k]); end
            nvec++; if (done !== 1'b0)      begin nerr++; $display("FAIL rmw_early_done[%0d] got %b want 0", k, done); end
            tick();
        end
        nvec++; if (done !== 1'b1)    begin nerr++; $display("FAIL rmw_done_c5 got %b want 1", done); end
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rmw_req_c5 got %b want 0", mem_req); end
        nvec++; if (valM !== 64'h0)   begin nerr++; $display("FAIL rmw_valM got %h want 0", valM); end
        tick();
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rmw_done_c6 got %b want 0", done); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmw_busy_c6 got %b want 0", busy); end
        mem_ack = 1'b0;
    endtask

    task automatic test_call();
        logic [63:0] ea [4] = '{64'h1F8, 64'h1FA, 64'h1FC, 64'h1FE};
        logic [15:0] ew [4] = '{16'h0ABC, 16'h0000, 16'h0000, 16'h0000};
        mem_ack = 1'b1;
        icode = 4'h8; valE = 64'h1F8; valA = 64'hFFFF_FFFF_FFFF_FFFF; valP = 64'hABC;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nvec++; if (mem_we !== 1'b1)    begin nerr++; $display("FAIL call_we[%0d] got %b want 1", k, mem_we); end
            nvec++; if (mem_addr !== ea[k]) begin nerr++; $display("FAIL call_addr[%0d] got %h want %h", k, mem_addr, ea[k]); end
            nvec++; if (mem_wdata !== ew[k]) begin nerr++; $display("FAIL call_wdata[%0d] got %h want %h", k, mem_wdata, ew[k]); end
            tick();
        end
        nvec++; if (done !== 1'b1)  begin nerr++; $display("FAIL call_done got %b want 1", done); end
        nvec++; if (valM !== 64'h0) begin nerr++; $display("FAIL call_valM got %h want 0", valM); end
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_popq_stall();
        logic [63:0] ea [4] = '{64'h200, 64'h202, 64'h204, 64'h206};
        logic [15:0] rd [4] = '{16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        mem_ack = 1'b0;
        icode = 4'hB; valA = 64'h200; valE = 64'h999; valP = 64'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 2; w++) begin
                nvec++; if (mem_req !== 1'b1)   begin nerr++; $display("FAIL pop_hold_req[%0d.%0d] got %b want 1", k, w, mem_req); end
                nvec++; if (mem_we !== 1'b0)    begin nerr++; $display("FAIL pop_hold_we[%0d.%0d] got %b want 0", k, w, mem_we); end
                nvec++; if (mem_addr !== ea[k]) begin nerr++; $display("FAIL pop_hold_addr[%0d.%0d] got %h want %h", k, w, mem_addr, ea[k]); end
                tick();
            end
            mem_ack = 1'b1; mem_rdata = rd[k];
            nvec++; if (mem_addr !== ea[k]) begin nerr++; $display("FAIL pop_ack_addr[%0d] got %h want %h", k, mem_addr, ea[k]); end
            tick();
            mem_ack = 1'b0; mem_rdata = 16'h0;
        end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL pop_done got %b want 1", done); end
        nvec++; if (valM !== 64'hAAAABBBBCCCCDDDD) begin nerr++; $display("FAIL pop_valM got %h want AAAABBBBCCCCDDDD", valM); end
        tick();
        // ack with no request must not start anything
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick(); tick();
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL idle_ack_req got %b want 0", mem_req); end
        nvec++; if (busy !== 1'b0)    begin nerr++; $display("FAIL idle_ack_busy got %b want 0", busy); end
        nvec++; if (valM !== 64'hAAAABBBBCCCCDDDD) begin nerr++; $display("FAIL idle_ack_valM got %h want AAAABBBBCCCCDDDD", valM); end
        mem_ack = 1'b0; mem_rdata = 16'h0;
    endtask

    task automatic test_none_class();
        icode = 4'h6; valE = 64'h40; valA = 64'h80; valP = 64'h0;
        start = 1'b1;
        tick();
        // second start while busy, with a write icode
        icode = 4'h4;
        nvec++; if (done !== 1'b1)    begin nerr++; $display("FAIL none_done_c1 got %b want 1", done); end
        nvec++; if (busy !== 1'b1)    begin nerr++; $display("FAIL none_busy_c1 got %b want 1", busy); end
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL none_req_c1 got %b want 0", mem_req); end
        nvec++; if (dmem_error !== 1'b0) begin nerr++; $display("FAIL none_err got %b want 0", dmem_error); end
        nvec++; if (valM !== 64'hAAAABBBBCCCCDDDD) begin nerr++; $display("FAIL none_valM got %h want AAAABBBBCCCCDDDD", valM); end
        tick();
        start = 1'b0;
        nvec++; if (busy !== 1'b0)    begin nerr++; $display("FAIL none_ignored_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0)    begin nerr++; $display("FAIL none_done_c2 got %b want 0", done); end
        tick();
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL none_ignored_req got %b want 0", mem_req); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] ea [4] = '{64'h300, 64'h302, 64'h304, 64'h306};
        logic [15:0] rd [4] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        icode = 4'h5; valE = 64'h300; valA = 64'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        nvec++; if (mem_addr !== 64'h304) begin nerr++; $display("FAIL rmid_beat2_addr got %h want 304", mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rmid_req got %b want 0", mem_req); end
        nvec++; if (busy !== 1'b0)    begin nerr++; $display("FAIL rmid_busy got %b want 0", busy); end
        nvec++; if (valM !== 64'h0)   begin nerr++; $display("FAIL rmid_valM got %h want 0", valM); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rmid_no_done[%0d] got %b want 0", c, done); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = rd[k];
            nvec++; if (mem_addr !== ea[k]) begin nerr++; $display("FAIL rmid_after_addr[%0d] got %h want %h", k, mem_addr, ea[k]); end
            tick();
        end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL rmid_after_done got %b want 1", done); end
        nvec++; if (valM !== 64'h1003100210011000) begin nerr++; $display("FAIL rmid_after_valM got %h want 1003100210011000", valM); end
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
    endtask

    task automatic test_align();
        mem_ack = 1'b1;
        icode = 4'h5; valE = 64'h103; valA = 64'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        nvec++; if (mem_req !== 1'b0)    begin nerr++; $display("FAIL align_req got %b want 0", mem_req); end
        nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL align_done got %b want 1", done); end
        nvec++; if (dmem_error !== 1'b1) begin nerr++; $display("FAIL align_err got %b want 1", dmem_error); end
        nvec++; if (valM !== 64'h1003100210011000) begin nerr++; $display("FAIL align_valM got %h want 1003100210011000", valM); end
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL align_busy got %b want 0", busy); end
`else
        begin
            logic [63:0] ea [4] = '{64'h103, 64'h105, 64'h107, 64'h109};
            logic [15:0] rd [4] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677};
            for (int k = 0; k < 4; k++) begin
                mem_rdata = rd[k];
                nvec++; if (mem_req !== 1'b1)   begin nerr++; $display("FAIL unal_req[%0d] got %b want 1", k, mem_req); end
                nvec++; if (mem_addr !== ea[k]) begin nerr++; $display("FAIL unal_addr[%0d] got %h want %h", k, mem_addr, ea[k]); end
                tick();
            end
            nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL unal_done got %b want 1", done); end
            nvec++; if (dmem_error !== 1'b0) begin nerr++; $display("FAIL unal_err got %b want 0", dmem_error); end
            nvec++; if (valM !== 64'h6677445522330011) begin nerr++; $display("FAIL unal_valM got %h want 6677445522330011", valM); end
            tick();
        end
`endif
        mem_ack = 1'b0; mem_rdata = 16'h0;
    endtask

    initial begin
        test_reset();
        test_irmmovq();
        test_call();
        test_popq_stall();
        test_none_class();
        test_reset_mid();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 64, memory address width in bits.
REQ-002 Parameter DATA_W, 64, stage data width in bits (valA/valP/valM).
REQ-003 Parameter BUS_W, 16, data-memory bus width; legal values 8/16/32/64, and it must divide DATA_W; N = DATA_W/BUS_W beats.
REQ-004 The block uses one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to perform the memory stage for icode.
REQ-008 icode  input  4  Y86-64 instruction code.
REQ-009 valE, valA, valP  input  ADDR_W/DATA_W/DATA_W  stage operands.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 valM  output  DATA_W  assembled read data, held until the next start.
REQ-013 dmem_error  output  1  set with done when the access faulted.
REQ-014 mem_req, mem_we  output  1 each  bus beat request and write qualifier.
REQ-015 mem_addr  output  ADDR_W  beat byte address.
REQ-016 mem_wdata  output  BUS_W  beat write data.
REQ-017 mem_ack  input  1  beat accepted; read data valid this cycle.
REQ-018 mem_rdata  input  BUS_W  beat read data.

Function
REQ-019 Write class: IRMMOVQ, IPUSHQ, ICALL. Read class: IMRMOVQ, IPOPQ, IRET. All other icodes are the none class.
REQ-020 Base address is valE for IRMMOVQ/IPUSHQ/ICALL/IMRMOVQ, and valA otherwise.
REQ-021 Write data is valP for ICALL, and valA otherwise.
REQ-022 FSM states: IDLE, BEAT, DONE. A start in IDLE moves to BEAT for read/write classes, or to DONE for the none class.
REQ-023 A start outside IDLE is ignored; busy=1 in BEAT and DONE.
REQ-024 In BEAT: mem_req=1, mem_we=1 for the write class only, mem_addr = base + k*(BUS_W/8) with k the beat index 0..N-1. Address arithmetic wraps modulo 2^ADDR_W.
REQ-025 A beat completes on a cycle with mem_req&&mem_ack; k increments. After beat N-1 completes, the FSM goes to DONE.
REQ-026 mem_req, mem_addr, mem_we and mem_wdata hold stable while mem_ack=0, with no timeout.
REQ-027 Data is little-endian: beat k carries bits [k*BUS_W +: BUS_W] for both write and read.
REQ-028 DONE lasts exactly one cycle with done=1, then the FSM returns to IDLE.
REQ-029 valM updates only for the read class. It is zero after reset and unchanged for the write and none classes.
REQ-030 Latency with mem_ack tied high: start at cycle 0 gives done at cycle N+1; the none class gives done at cycle 1.
REQ-031 mem_ack while mem_req=0 is ignored.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, k=0, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, valM=0, dmem_error=0.
REQ-033 Reset mid-transfer abandons the access with no done pulse; partial read data is discarded.

Configuration
REQ-034 Macro MEM_ALIGN_CHECK_EN.
- Defined: a read/write-class start whose base is not a multiple of DATA_W/8 issues no beats, goes directly to DONE, and asserts dmem_error with done; valM is unchanged.
- Undefined: there is no check, and dmem_error is constant 0.

Structure
REQ-035 Icode constants (IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B) and the FSM state encoding live in the shared cpu_definitions package.
REQ-036 One sub-module, mem_beat_pack, holds the beat counter plus the write-slice and read-assembly shift register.

Verification
REQ-037 BUS_W=16, ack tied high, IRMMOVQ, valE=0x100, valA=0x1122334455667788 -> beats at 0x100/102/104/106 with wdata 7788/5566/3344/1122; done at cycle 5.
REQ-038 ICALL, valE=0x1F8, valP=0xABC -> four writes starting at 0x1F8; beat 0 wdata=0x0ABC, remaining beats 0.
REQ-039 IPOPQ, valA=0x200, rdata 0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA with 2-cycle ack delays -> outputs held stable while waiting; valM=0xAAAABBBBCCCCDDDD.
REQ-040 IOPQ (icode 6) start -> no mem_req; done at cycle 1; valM unchanged; a second start while busy is ignored.
REQ-041 rst_n pulsed low during beat 2 of IMRMOVQ -> mem_req drops immediately, no done; a following access behaves normally.
REQ-042 With MEM_ALIGN_CHECK_EN, IMRMOVQ at valE=0x103 -> no mem_req; done and dmem_error at cycle 1. Without it -> normal 4-beat read at 0x103.
